mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single mem_if Avalon-MM slave port between two masters:
  - m0: stimulus/host side, read and write.
  - m1: result checker, write-only writeback.
- Round-robin grant, with a lock input so a master's multi-word writeback is never interleaved.
- A hold limit prevents one master from starving the other.
- Sits between the stim/check blocks and mem_if.

Parameters:
- ADDR_WIDTH, 20, word address width.
- DATA_WIDTH, 16, data width.
- BE_WIDTH, DATA_WIDTH/8, byteenable width.
- MAX_HOLD, 8, maximum back-to-back accepted transfers per grant while the other master waits (lock not asserted).
- HOLD_WIDTH, 4, width of the hold counter; must satisfy 2^HOLD_WIDTH > MAX_HOLD.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- m0_address  in  ADDR_WIDTH  master 0 address.
- m0_byteenable  in  BE_WIDTH  master 0 byteenable.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_WIDTH  master 0 write data.
- m0_lock  in  1  master 0 keeps its grant across transfers.
- m0_readdata  out  DATA_WIDTH  read data.
- m0_waitrequest  out  1  stall to master 0.
- m1_address  in  ADDR_WIDTH  master 1 address.
- m1_byteenable  in  BE_WIDTH  master 1 byteenable.
- m1_write  in  1  master 1 write request.
- m1_writedata  in  DATA_WIDTH  master 1 write data.
- m1_lock  in  1  master 1 keeps its grant across transfers.
- m1_waitrequest  out  1  stall to master 1.
- mem_address  out  ADDR_WIDTH  to mem_if.
- mem_byteenable  out  BE_WIDTH  to mem_if.
- mem_read  out  1  to mem_if.
- mem_write  out  1  to mem_if.
- mem_writedata  out  DATA_WIDTH  to mem_if.
- mem_readdata  in  DATA_WIDTH  from mem_if; valid in the cycle mem_read && !mem_waitrequest.
- mem_waitrequest  in  1  from mem_if.
- grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Requests: req0 = m0_read | m0_write; req1 = m1_write.
- State register: IDLE, OWN0, OWN1. Also registered: last (last owner, reset 1 so m0 wins first tie) and hold_cnt (reset 0).
- Reset values: state IDLE; grant 00; mem_read/mem_write 0; m0_waitrequest and m1_waitrequest 1.
- IDLE:
  - Only one of req0/req1 set → go to that OWNx.
  - Both set → grant the master != last.
  - No transfer is issued in IDLE, so grant latency is one cycle: a request seen in cycle t is presented to mem_if at t+1.
- OWNx datapath:
  - mem_* are muxed combinationally from master x.
  - mx_waitrequest = mem_waitrequest.
  - The other master's waitrequest = 1.
  - m0_readdata = mem_readdata always; it is only meaningful when m0 is granted.
- Accepted transfer: (mem_read | mem_write) && !mem_waitrequest. Each accepted transfer increments hold_cnt, saturating at MAX_HOLD.
- Leaving OWNx: evaluated every cycle, no transfer pending or accepted.
  - If !reqx && !lockx: go to OWNother if the other master requests, else IDLE. Set last = x and clear hold_cnt.
  - If lockx: stay, regardless of hold_cnt.
  - If reqx && !lockx && hold_cnt == MAX_HOLD && the other master requests: switch to the other master once the current transfer is accepted (not mid-stall). Clear hold_cnt and set last = x.
- A transfer stalled by mem_waitrequest is never abandoned: the grant cannot change while mx request && mem_waitrequest.
- m0_read && m0_write together: forwarded unchanged; this is a protocol error, not checked.
- Reset mid-transfer: everything returns to reset values next cycle and mem_read/mem_write drop immediately. The in-flight transfer is lost and masters must be reset too.
- grant equals the one-hot encoding of state.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_xfer0 and stat_xfer1 (32-bit each): accepted-transfer counts per master.
  - Adds output stat_wait1 (32-bit): cycles with req1 asserted and m1 not granted.
  - All three reset to 0, wrap on overflow, and are cleared by reset only.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg:
  - State encodings (IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10), so state equals grant directly.
  - Master index constants M0 = 0, M1 = 1.
- One natural sub-module, mem_arb_mux: purely combinational selection of the mem_* and waitrequest signals from grant. The FSM and counters stay in mem_arbiter.

Test Plan:
- Single requester: m1_write at address 0x00010, data 0xBEEF, mem_waitrequest 0 → grant = 10 one cycle later; mem_write = 1 with 0x00010/0xBEEF for exactly one cycle; back to IDLE.
- Tie after reset: req0 and req1 rise in the same cycle → m0 granted first; m1 granted the cycle after m0 drops its request; then a further tie → m0 wins again (last = 1).
- Lock: m1 asserts lock and writes 2 words while m0_read is held → both m1 words complete back-to-back; m0 is granted only after m1_lock drops; m0_waitrequest stays 1 throughout.
- Hold limit: m0 streams 20 reads without lock while m1 requests, MAX_HOLD = 8 → m1 granted after exactly 8 accepted m0 reads.
- Stall: mem_waitrequest held high 5 cycles during an m0 write while m1 requests → grant stays 01 until the write is accepted; mem_address and mem_writedata stable throughout.
- Reset mid-transfer: reset asserted during an OWN1 stall → next cycle grant 00, mem_write 0, both waitrequests 1; with MEM_ARB_STATS_EN defined, all stats read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter.
// State encodings equal the one-hot grant so the state register drives grant directly.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam int M0 = 0;
  localparam int M1 = 1;

endpackage

// File: rtl/mem_arb_mux.sv
// Combinational steering of the mem_if port and the waitrequests from the current grant.
module mem_arb_mux
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  reset,
  input  logic [1:0]            grant,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic                  mem_waitrequest
);

  // Reset gates the strobes in the same cycle so an in-flight transfer drops at once.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (grant[M1]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
    if (!reset) begin
      if (grant[M1]) begin
        mem_write      = m1_write;
        m1_waitrequest = mem_waitrequest;
      end else if (grant[M0]) begin
        mem_read       = m0_read;
        mem_write      = m0_write;
        m0_waitrequest = mem_waitrequest;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with lock and hold limit sharing mem_if between m0 and m1.
// Define MEM_ARB_STATS_EN to add per-master transfer and m1 wait counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_HOLD   = 8,
  parameter int HOLD_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  input  logic                  m0_lock,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  input  logic                  m1_lock,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_waitrequest,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]           stat_xfer0,
  output logic [31:0]           stat_xfer1,
  output logic [31:0]           stat_wait1,
`endif
  output logic [1:0]            grant
);

  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(MAX_HOLD);

  arb_state_t            state;
  logic                  last_owner;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic [HOLD_WIDTH-1:0] hold_next;
  logic                  req0, req1, accepted;
  logic                  own_req, own_lock, other_req, own_idx;
  arb_state_t            other_state;

  assign req0        = m0_read | m0_write;
  assign req1        = m1_write;
  assign accepted    = (mem_read | mem_write) && !mem_waitrequest;
  assign hold_next   = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_WIDTH'(accepted);
  assign grant       = state;
  assign m0_readdata = mem_readdata;

  always_comb begin
    own_req     = 1'b0;
    own_lock    = 1'b0;
    other_req   = 1'b0;
    own_idx     = 1'b0;
    other_state = IDLE;
    if (state == OWN0) begin
      own_req     = req0;
      own_lock    = m0_lock;
      other_req   = req1;
      own_idx     = 1'b0;
      other_state = OWN1;
    end else if (state == OWN1) begin
      own_req     = req1;
      own_lock    = m1_lock;
      other_req   = req0;
      own_idx     = 1'b1;
      other_state = OWN0;
    end
  end

  // The hold-limit handover waits for the owner's transfer to be accepted, never mid-stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else if (state == IDLE) begin
      if (req0 && (!req1 || last_owner)) state <= OWN0;
      else if (req1)                     state <= OWN1;
    end else if (own_lock) begin
      hold_cnt <= hold_next;
    end else if (!own_req) begin
      state      <= other_req ? other_state : IDLE;
      last_owner <= own_idx;
      hold_cnt   <= '0;
    end else if (hold_next == HOLD_MAX && other_req && !mem_waitrequest) begin
      state      <= other_state;
      last_owner <= own_idx;
      hold_cnt   <= '0;
    end else begin
      hold_cnt <= hold_next;
    end
  end

  mem_arb_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BE_WIDTH  (BE_WIDTH)
  ) u_mux (
    .reset          (reset),
    .grant          (grant),
    .m0_address     (m0_address),
    .m0_byteenable  (m0_byteenable),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_byteenable  (m1_byteenable),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_waitrequest (m1_waitrequest),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_waitrequest(mem_waitrequest)
  );

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_xfer0 <= '0;
      stat_xfer1 <= '0;
      stat_wait1 <= '0;
    end else begin
      if (accepted && state == OWN0) stat_xfer0 <= stat_xfer0 + 32'd1;
      if (accepted && state == OWN1) stat_xfer1 <= stat_xfer1 + 32'd1;
      if (req1 && state != OWN1)     stat_wait1 <= stat_wait1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then random traffic against an ownership model.
module tb_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int MAX_HOLD = 8;

  logic          clock, reset;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m0_lock, m0_waitrequest;
  logic          m1_write, m1_lock, m1_waitrequest;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, mem_writedata, mem_readdata;
  logic          mem_read, mem_write, mem_waitrequest;
  logic [1:0]    grant;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   stat_xfer0, stat_xfer1, stat_wait1;
`endif

  int assertions = 0;
  int failures   = 0;

  // Reference model: who owns the port, who owned it last, transfers in this grant.
  int          owner, last_own, held;
  int unsigned sx0, sx1, sw1;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_lock(m1_lock), .m1_waitrequest(m1_waitrequest),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest),
`ifdef MEM_ARB_STATS_EN
    .stat_xfer0(stat_xfer0), .stat_xfer1(stat_xfer1), .stat_wait1(stat_wait1),
`endif
    .grant(grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs;
    m0_address = '0; m0_byteenable = 2'b11; m0_read = 0; m0_write = 0;
    m0_writedata = '0; m0_lock = 0;
    m1_address = '0; m1_byteenable = 2'b11; m1_write = 0; m1_writedata = '0; m1_lock = 0;
    mem_readdata = '0; mem_waitrequest = 0;
  endtask

  task automatic applyReset;
    reset = 1;
    idleInputs();
    repeat (2) cyc();
    reset = 0;
    owner = -1; last_own = 1; held = 0;
    sx0 = 0; sx1 = 0; sw1 = 0;
  endtask

  task automatic applyStimulus;
    int r;
    r = $urandom_range(0, 3);
    m0_read  = (r == 1);
    m0_write = (r == 2);
    m1_write = ($urandom_range(0, 2) != 0);
    m0_lock  = ($urandom_range(0, 9) == 0);
    m1_lock  = ($urandom_range(0, 9) == 0);
    mem_waitrequest = ($urandom_range(0, 3) == 0);
    m0_address   = AW'($urandom);
    m1_address   = AW'($urandom);
    m0_writedata = DW'($urandom);
    m1_writedata = DW'($urandom);
    mem_readdata = DW'($urandom);
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep;
    bit req [2];
    bit lck [2];
    bit acc;
    int x, y, hnew;
    req[0] = m0_read | m0_write;  req[1] = m1_write;
    lck[0] = m0_lock;             lck[1] = m1_lock;
    if (req[1] && owner != 1) sw1++;
    if (owner < 0) begin
      if (req[0] && req[1]) owner = (last_own == 1) ? 0 : 1;
      else if (req[0])      owner = 0;
      else if (req[1])      owner = 1;
    end else begin
      x = owner; y = 1 - x;
      acc = req[x] && !mem_waitrequest;
      if (acc && x == 0) sx0++;
      if (acc && x == 1) sx1++;
      hnew = (held + int'(acc) > MAX_HOLD) ? MAX_HOLD : held + int'(acc);
      if (lck[x]) held = hnew;
      else if (!req[x]) begin
        owner = req[y] ? y : -1; last_own = x; held = 0;
      end else if (acc && hnew == MAX_HOLD && req[y]) begin
        owner = y; last_own = x; held = 0;
      end else held = hnew;
    end
  endtask

  initial begin
    int cnt;
    bit done;
    reset = 1;
    idleInputs();

    applyReset();
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'h0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'h0);
    checkOutput("rst_wr0", 32'(m0_waitrequest), 32'h1);
    checkOutput("rst_wr1", 32'(m1_waitrequest), 32'h1);
`ifdef MEM_ARB_STATS_EN
    checkOutput("rst_stats", stat_xfer0 | stat_xfer1 | stat_wait1, 32'h0);
`endif

    // Single requester
    cyc(); m1_write = 1; m1_address = 20'h00010; m1_writedata = 16'hBEEF; #1;
    checkOutput("single_idle_grant", 32'(grant), 32'h0);
    checkOutput("single_idle_wr1", 32'(m1_waitrequest), 32'h1);
    cyc(); #1;
    checkOutput("single_grant", 32'(grant), 32'h2);
    checkOutput("single_write", 32'(mem_write), 32'h1);
    checkOutput("single_addr", 32'(mem_address), 32'h00010);
    checkOutput("single_data", 32'(mem_writedata), 32'hBEEF);
    checkOutput("single_wr1", 32'(m1_waitrequest), 32'h0);
    cyc(); m1_write = 0; #1;
    checkOutput("single_after_write", 32'(mem_write), 32'h0);
    cyc(); #1;
    checkOutput("single_back_idle", 32'(grant), 32'h0);

    // Tie after reset: m0 first, then m1, then m0 wins a fresh tie
    applyReset();
    cyc(); m0_read = 1; m0_address = 20'h20; m1_write = 1; m1_address = 20'h30; mem_readdata = 16'h1234; #1;
    checkOutput("tie_idle", 32'(grant), 32'h0);
    cyc(); #1;
    checkOutput("tie_first_m0", 32'(grant), 32'h1);
    checkOutput("tie_read", 32'(mem_read), 32'h1);
    checkOutput("tie_addr0", 32'(mem_address), 32'h20);
    checkOutput("tie_readdata", 32'(m0_readdata), 32'h1234);
    checkOutput("tie_wr1_stalled", 32'(m1_waitrequest), 32'h1);
    cyc(); m0_read = 0; #1;
    checkOutput("tie_m0_drop", 32'(grant), 32'h1);
    cyc(); #1;
    checkOutput("tie_then_m1", 32'(grant), 32'h2);
    checkOutput("tie_addr1", 32'(mem_address), 32'h30);
    cyc(); m1_write = 0; #1;
    cyc(); m0_read = 1; m1_write = 1; #1;
    checkOutput("tie2_idle", 32'(grant), 32'h0);
    cyc(); #1;
    checkOutput("tie2_m0_wins", 32'(grant), 32'h1);
    cyc(); m0_read = 0; m1_write = 0; #1;
    cyc(); #1;

    // Lock: m1 writes two words with m0 waiting
    cyc(); m1_write = 1; m1_lock = 1; m1_address = 20'h40; m0_read = 1; #1;
    cyc(); #1;
    checkOutput("lock_grant_w1", 32'(grant), 32'h2);
    checkOutput("lock_addr_w1", 32'(mem_address), 32'h40);
    checkOutput("lock_wr0_w1", 32'(m0_waitrequest), 32'h1);
    cyc(); m1_address = 20'h41; #1;
    checkOutput("lock_addr_w2", 32'(mem_address), 32'h41);
    checkOutput("lock_write_w2", 32'(mem_write), 32'h1);
    cyc(); m1_write = 0; #1;
    checkOutput("lock_held_grant", 32'(grant), 32'h2);
    checkOutput("lock_held_wr0", 32'(m0_waitrequest), 32'h1);
    cyc(); m1_lock = 0; #1;
    checkOutput("lock_release_grant", 32'(grant), 32'h2);
    cyc(); #1;
    checkOutput("lock_m0_granted", 32'(grant), 32'h1);
    checkOutput("lock_m0_wr0", 32'(m0_waitrequest), 32'h0);
    cyc(); m0_read = 0; #1;
    cyc(); #1;

    // Hold limit: m0 streams reads while m1 waits
    cyc(); m0_read = 1; #1;
    cnt = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc(); m1_write = 1; m0_address = AW'(32'h100 + cnt); #1;
      if (grant == 2'b10) done = 1;
      else if (grant == 2'b01 && mem_read && !m0_waitrequest) cnt++;
    end
    checkOutput("hold_reads", 32'(cnt), 32'(MAX_HOLD));
    checkOutput("hold_grant_m1", 32'(grant), 32'h2);
    cyc(); m1_write = 0; #1;
    cyc(); #1;
    checkOutput("hold_back_m0", 32'(grant), 32'h1);
    cyc(); m0_read = 0; #1;
    cyc(); #1;

    // Stall: m0 write held off by mem_waitrequest while m1 requests
    cyc(); m0_write = 1; m0_address = 20'h55; m0_writedata = 16'hA5A5; mem_waitrequest = 1; #1;
    for (int i = 0; i < 5; i++) begin
      cyc(); m1_write = 1; #1;
      checkOutput("stall_grant", 32'(grant), 32'h1);
      checkOutput("stall_addr", 32'(mem_address), 32'h55);
      checkOutput("stall_data", 32'(mem_writedata), 32'hA5A5);
      checkOutput("stall_wr0", 32'(m0_waitrequest), 32'h1);
    end
    cyc(); mem_waitrequest = 0; #1;
    checkOutput("stall_accept_grant", 32'(grant), 32'h1);
    checkOutput("stall_accept_wr0", 32'(m0_waitrequest), 32'h0);
    cyc(); m0_write = 0; #1;
    cyc(); #1;
    checkOutput("stall_then_m1", 32'(grant), 32'h2);
    cyc(); m1_write = 0; #1;
    cyc(); #1;

    // Reset during an m1 stall
    cyc(); m1_write = 1; m1_address = 20'h77; mem_waitrequest = 1; #1;
    cyc(); #1;
    checkOutput("rmid_grant", 32'(grant), 32'h2);
    cyc(); reset = 1; #1;
    checkOutput("rmid_write_drop", 32'(mem_write), 32'h0);
    checkOutput("rmid_wr1_now", 32'(m1_waitrequest), 32'h1);
    cyc(); #1;
    checkOutput("rmid_grant_idle", 32'(grant), 32'h0);
    checkOutput("rmid_write", 32'(mem_write), 32'h0);
    checkOutput("rmid_wr0", 32'(m0_waitrequest), 32'h1);
    checkOutput("rmid_wr1", 32'(m1_waitrequest), 32'h1);
`ifdef MEM_ARB_STATS_EN
    checkOutput("rmid_stats", stat_xfer0 | stat_xfer1 | stat_wait1, 32'h0);
`endif

    // Random traffic against the ownership model
    applyReset();
    for (int c = 0; c < 400; c++) begin
      cyc();
      applyStimulus();
      #1;
      checkOutput("rnd_grant", 32'(grant), (owner < 0) ? 32'h0 : (32'h1 << owner));
      checkOutput("rnd_mem_read", 32'(mem_read), 32'(owner == 0 && m0_read));
      checkOutput("rnd_mem_write", 32'(mem_write),
                  32'((owner == 0 && m0_write) || (owner == 1 && m1_write)));
      checkOutput("rnd_wr0", 32'(m0_waitrequest), (owner == 0) ? 32'(mem_waitrequest) : 32'h1);
      checkOutput("rnd_wr1", 32'(m1_waitrequest), (owner == 1) ? 32'(mem_waitrequest) : 32'h1);
      checkOutput("rnd_readdata", 32'(m0_readdata), 32'(mem_readdata));
      if (owner >= 0)
        checkOutput("rnd_addr", 32'(mem_address), (owner == 1) ? 32'(m1_address) : 32'(m0_address));
      modelStep();
    end
    cyc(); idleInputs(); #1;
`ifdef MEM_ARB_STATS_EN
    checkOutput("rnd_stat_xfer0", stat_xfer0, sx0);
    checkOutput("rnd_stat_xfer1", stat_xfer1, sx1);
    checkOutput("rnd_stat_wait1", stat_wait1, sw1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
